sdp_fifo_ctrl: RTL and testbench

//  Sequencer that turns one external simple-dual-port block RAM (1-cycle registered

---
 rtl/sdp_fifo_ctrl.sv | 117 +++++++++++
 tb/tb_sdp_fifo_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_fifo_ctrl.sv
// sdp_fifo_ctrl: sequencer that wraps one external simple-dual-port block RAM
// (1-cycle registered read) into a first-word-fall-through FIFO. The RAM output
// register serves as the FIFO output stage, so the head word lives in the RAM
// and is only re-read when the consumer takes it.
module sdp_fifo_ctrl #(
  parameter int unsigned RAM_WIDTH = 8,
  parameter int unsigned RAM_DEPTH = 128,
  parameter int unsigned AFULL_LVL = 96,
  localparam int unsigned AW       = $clog2(RAM_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_flush,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  input  logic [RAM_WIDTH-1:0] i_wr_data,
  output logic                 o_rd_valid,
  input  logic                 i_rd_ready,
  output logic [RAM_WIDTH-1:0] o_rd_data,
  output logic [AW:0]          o_level,
  output logic                 o_almost_full,
  output logic                 o_ram_ena,
  output logic                 o_ram_wea,
  output logic [AW-1:0]        o_ram_addra,
  output logic [RAM_WIDTH-1:0] o_ram_dina,
  output logic                 o_ram_enb,
  output logic [AW-1:0]        o_ram_addrb,
  input  logic [RAM_WIDTH-1:0] i_ram_doutb
);

  localparam logic [AW:0]   CntFull = (AW + 1)'(RAM_DEPTH);
  localparam logic [AW:0]   CntOne  = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrOne  = AW'(1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  // Words written to the RAM but not yet fetched into its output register.
  logic [AW:0]   ram_cnt_q, ram_cnt_d;
  logic          rd_valid_q, rd_valid_d;

  logic wr_ready;
  logic push;
  logic pop;
  logic fetch;

  // Handshakes and the RAM read decision; flush blocks both RAM ports.
  always_comb begin
    wr_ready = (ram_cnt_q != CntFull) & ~i_flush;
    push     = i_wr_valid & wr_ready;
    pop      = rd_valid_q & i_rd_ready;
    // A word pushed this cycle is not yet in ram_cnt_q, so a fetch never reads
    // the address being written in the same cycle.
    fetch    = (ram_cnt_q != '0) & (~rd_valid_q | i_rd_ready) & ~i_flush;
  end

  // Next-state for pointers, RAM occupancy and the output-valid flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    rd_valid_d = rd_valid_q;
    if (i_flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ram_cnt_d  = '0;
      rd_valid_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (fetch) begin
        rd_ptr_d = rd_ptr_q + PtrOne;
      end
      if (push && !fetch) begin
        ram_cnt_d = ram_cnt_q + CntOne;
      end else if (fetch && !push) begin
        ram_cnt_d = ram_cnt_q - CntOne;
      end
      if (fetch) begin
        rd_valid_d = 1'b1;
      end else if (pop) begin
        rd_valid_d = 1'b0;
      end
    end
  end

  // State registers; RAM contents are deliberately left untouched by reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Output mapping: the RAM read register is the FIFO head.
  always_comb begin
    o_wr_ready    = wr_ready;
    o_rd_valid    = rd_valid_q;
    o_rd_data     = i_ram_doutb;
    o_level       = ram_cnt_q + {{AW{1'b0}}, rd_valid_q};
    o_almost_full = 32'(o_level) >= AFULL_LVL;
    o_ram_ena     = push;
    o_ram_wea     = push;
    o_ram_addra   = wr_ptr_q;
    o_ram_dina    = i_wr_data;
    o_ram_enb     = fetch;
    o_ram_addrb   = rd_ptr_q;
  end

endmodule

// File: tb/tb_sdp_fifo_ctrl.sv
// Bench for sdp_fifo_ctrl with a small behavioural SDP RAM (depth 4) and a
// queue scoreboard: words are queued on accepted writes and compared on pops.
module tb_sdp_fifo_ctrl;

  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AFULL = 3;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rstn;
  logic          flush;
  logic          wr_valid;
  logic          wr_ready;
  logic [W-1:0]  wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [W-1:0]  rd_data;
  logic [AW:0]   level;
  logic          almost_full;
  logic          ram_ena;
  logic          ram_wea;
  logic [AW-1:0] ram_addra;
  logic [W-1:0]  ram_dina;
  logic          ram_enb;
  logic [AW-1:0] ram_addrb;
  logic [W-1:0]  ram_doutb;

  logic [W-1:0]  mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int npop     = 0;
  int first_pop;
  int last_pop;
  logic [W-1:0] q[$];

  always #5 clk = ~clk;

  // Behavioural RAM: registered read, old data on same-address collision.
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_enb) ram_doutb <= mem[ram_addrb];
  end

  sdp_fifo_ctrl #(
    .RAM_WIDTH (W),
    .RAM_DEPTH (DEPTH),
    .AFULL_LVL (AFULL)
  ) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_flush       (flush),
    .i_wr_valid    (wr_valid),
    .o_wr_ready    (wr_ready),
    .i_wr_data     (wr_data),
    .o_rd_valid    (rd_valid),
    .i_rd_ready    (rd_ready),
    .o_rd_data     (rd_data),
    .o_level       (level),
    .o_almost_full (almost_full),
    .o_ram_ena     (ram_ena),
    .o_ram_wea     (ram_wea),
    .o_ram_addra   (ram_addra),
    .o_ram_dina    (ram_dina),
    .o_ram_enb     (ram_enb),
    .o_ram_addrb   (ram_addrb),
    .i_ram_doutb   (ram_doutb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    wr_valid = v;
    wr_data  = d;
    rd_ready = r;
    flush    = f;
  endtask

  // Evaluate handshakes after inputs settle, update the scoreboard.
  task automatic settle();
    logic push, pop;
    #1;
    push = wr_valid & wr_ready;
    pop  = rd_valid & rd_ready;
    if (flush) begin
      check("ready_in_flush", 32'(wr_ready), 0);
      check("ena_in_flush", 32'(ram_ena), 0);
      check("enb_in_flush", 32'(ram_enb), 0);
      q.delete();
    end else begin
      if (q.size() == DEPTH + 1) check("ready_when_full", 32'(wr_ready), 0);
      else if (q.size() < DEPTH) check("ready_not_full", 32'(wr_ready), 1);
      if (pop) begin
        check("pop_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) check("pop_data", 32'(rd_data), 32'(q.pop_front()));
        if (npop == 0) first_pop = cyc;
        last_pop = cyc;
        npop++;
      end
      if (push) begin
        check("wr_en", 32'({ram_ena, ram_wea}), 32'b11);
        q.push_back(wr_data);
      end
    end
  endtask

  // Clock edge, then post-edge level/flag checks against the scoreboard.
  task automatic advance();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("level", 32'(level), 32'(q.size()));
    check("almost_full", 32'(almost_full), 32'(q.size() >= AFULL));
    if (q.size() == 0) check("valid_when_empty", 32'(rd_valid), 0);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
    end
    check("drain_empty", 32'(q.size()), 0);
  endtask

  task automatic async_reset();
    #2 rstn = 1'b0;
    #1;
    q.delete();
    check("rst_level", 32'(level), 0);
    check("rst_valid", 32'(rd_valid), 0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Reset pulse while idle.
    async_reset();
    #1;
    check("rst_wr_ready", 32'(wr_ready), 1);
    check("rst_ena", 32'(ram_ena), 0);
    check("rst_enb", 32'(ram_enb), 0);
    tick();

    // Single word: 2-cycle latency, held while not ready.
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    settle();
    check("sw_wea", 32'(ram_wea), 1);
    check("sw_addra", 32'(ram_addra), 0);
    advance();
    drive(1'b0, '0, 1'b0, 1'b0);
    settle();
    check("sw_enb", 32'(ram_enb), 1);
    check("sw_addrb", 32'(ram_addrb), 0);
    check("sw_valid_early", 32'(rd_valid), 0);
    advance();
    for (int i = 0; i < 10; i++) begin
      settle();
      check("sw_hold_valid", 32'(rd_valid), 1);
      check("sw_hold_data", 32'(rd_data), 32'hA5);
      check("sw_hold_enb", 32'(ram_enb), 0);
      advance();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    check("sw_after_pop_valid", 32'(rd_valid), 0);

    // Fill: five words fit, sixth waits for one pop.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, W'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 8'h06, 1'b0, 1'b0);
    settle();
    check("fill_ready_low", 32'(wr_ready), 0);
    check("fill_level", 32'(level), 5);
    advance();
    drive(1'b1, 8'h06, 1'b1, 1'b0);
    settle();
    check("fill_ready_pop_cycle", 32'(wr_ready), 0);
    advance();
    drive(1'b1, 8'h06, 1'b0, 1'b0);
    settle();
    check("fill_ready_back", 32'(wr_ready), 1);
    advance();
    drain();

    // Streaming with wrap: one word out per cycle.
    npop = 0;
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0);
      tick();
    end
    drain();
    check("stream_npop", 32'(npop), 20);
    check("stream_no_bubbles", 32'(last_pop - first_pop), 19);

    // Random backpressure.
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 2) != 0), 1'b0);
      tick();
    end
    drain();

    // Flush with three words held.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, W'(8'h30 + i), 1'b0, 1'b0);
      tick();
    end
    check("pre_flush_level", 32'(level), 3);
    drive(1'b1, 8'hEE, 1'b1, 1'b1);
    tick();
    check("flush_valid", 32'(rd_valid), 0);
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    settle();
    check("flush_addra", 32'(ram_addra), 0);
    advance();
    drain();

    // Async reset in the middle of a stream.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, W'(8'h50 + i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 8'h99, 1'b1, 1'b0);
    async_reset();
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    settle();
    check("post_rst_addra", 32'(ram_addra), 0);
    advance();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
